// File: rtl/prefetch_queue_if.sv
// Handshake bundle for prefetch_queue: instruction-memory read port,
// redirect/halt control, decode window and decode consume port.
// The slave modport is the prefetch queue itself; the master modport is
// whatever surrounds it (memory + decode, or a testbench).
interface prefetch_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // instruction memory side
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  // fetch control
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          halt;

  // decode side
  logic [39:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic [CW-1:0] byte_count;
  logic          consume;
  logic [2:0]    consume_len;

  // statistics
  logic [31:0]   stall_cycles;

  modport slave (
    output mem_req, mem_addr,
    input  mem_rvalid, mem_rdata,
    input  redirect, redirect_pc, halt,
    output instr, instr_pc, instr_valid, byte_count,
    input  consume, consume_len,
    output stall_cycles
  );

  modport master (
    input  mem_req, mem_addr,
    output mem_rvalid, mem_rdata,
    output redirect, redirect_pc, halt,
    input  instr, instr_pc, instr_valid, byte_count,
    output consume, consume_len,
    input  stall_cycles
  );
endinterface

// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-granular instruction prefetch buffer.
// Fetches aligned 32-bit words (one request outstanding at most), stores
// the bytes in a DEPTH-byte circular queue and presents a 5-byte
// little-endian window at the head PC to decode.
// Optional feature: define PREFETCH_STATS_EN to build the saturating
// starvation counter on stall_cycles; otherwise stall_cycles is tied to 0.
module prefetch_queue #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  prefetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_WAIT = 2'd1,  // request outstanding, response will be written
    S_DROP = 2'd2   // request outstanding, response is stale (redirected)
  } state_t;

  state_t         r_state;
  logic           r_run;
  logic [31:0]    r_fetch_addr;
  logic [31:0]    r_instr_pc;
  logic [1:0]     r_first_off;
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [7:0]     r_mem [DEPTH];

  logic           w_issue;
  logic           w_wr_en;
  logic           w_cons_en;
  logic           w_instr_valid;
  logic [2:0]     w_wr_n;
  logic [CW-1:0]  w_wr_amt;
  logic [CW-1:0]  w_cons_amt;
  logic [3:0]     w_lane_en;
  logic [AW-1:0]  w_lane_addr [4];
  logic [7:0]     w_lane_data [4];
  logic [39:0]    w_instr;

  // r_run keeps mem_req low while reset is held and for the first edge
  // after release, so the combinational request never fires inside reset.
  assign w_issue = r_run && (r_state == S_IDLE) && !bus.halt && !bus.redirect &&
                   ((32'(r_count) + 32'd4) <= 32'(DEPTH));

  // A response is only written in WAIT and only if no redirect flushes it.
  assign w_wr_en   = (r_state == S_WAIT) && bus.mem_rvalid && !bus.redirect;
  assign w_wr_n    = 3'd4 - {1'b0, r_first_off};
  assign w_wr_amt  = w_wr_en ? CW'(w_wr_n) : '0;

  assign w_instr_valid = (r_count >= CW'(5));
  assign w_cons_en     = bus.consume && w_instr_valid && !bus.redirect;
  assign w_cons_amt    = w_cons_en ? CW'(bus.consume_len) : '0;

  // Byte lanes of the incoming word: lanes below first_off are skipped,
  // the rest are packed contiguously starting at the tail.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_en[gi]   = w_wr_en && (2'(gi) >= r_first_off);
    assign w_lane_addr[gi] = r_tail + AW'(gi) - AW'(r_first_off);
    assign w_lane_data[gi] = bus.mem_rdata[8*gi +: 8];
  end

  // Decode window: five consecutive bytes from the head, wrapping.
  for (genvar gi = 0; gi < 5; gi++) begin : g_win
    assign w_instr[8*gi +: 8] = r_mem[r_head + AW'(gi)];
  end

  assign bus.mem_req     = w_issue;
  assign bus.mem_addr    = r_fetch_addr;
  assign bus.instr       = w_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = w_instr_valid;
  assign bus.byte_count  = r_count;

  // Byte storage: write the enabled lanes of an accepted response.
  // Contents need no reset; validity is tracked by count/head/tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_lane_en[i]) begin
        r_mem[w_lane_addr[i]] <= w_lane_data[i];
      end
    end
  end

  // Fetch FSM, pointers, count and PCs; redirect overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_instr_pc   <= RESET_PC;
      r_first_off  <= RESET_PC[1:0];
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      r_run <= 1'b1;
      if (bus.redirect) begin
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= '0;
        r_instr_pc   <= bus.redirect_pc;
        r_fetch_addr <= {bus.redirect_pc[31:2], 2'b00};
        r_first_off  <= bus.redirect_pc[1:0];
        // A response landing in the redirect cycle retires the outstanding
        // request (its data is discarded), so no DROP wait is needed then.
        case (r_state)
          S_WAIT:  r_state <= bus.mem_rvalid ? S_IDLE : S_DROP;
          S_DROP:  r_state <= bus.mem_rvalid ? S_IDLE : S_DROP;
          default: r_state <= S_IDLE;
        endcase
      end else begin
        r_count <= r_count + w_wr_amt - w_cons_amt;
        if (w_wr_en) begin
          r_tail      <= r_tail + AW'(w_wr_n);
          r_first_off <= 2'd0;
        end
        if (w_cons_en) begin
          r_head     <= r_head + AW'(bus.consume_len);
          r_instr_pc <= r_instr_pc + 32'(bus.consume_len);
        end
        case (r_state)
          S_IDLE: begin
            if (w_issue) begin
              r_state      <= S_WAIT;
              r_fetch_addr <= r_fetch_addr + 32'd4;
            end
          end
          S_WAIT: begin
            if (bus.mem_rvalid) r_state <= S_IDLE;
          end
          S_DROP: begin
            if (bus.mem_rvalid) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] r_stall;

  // Starvation counter: counts non-halted, non-redirect cycles without a
  // full window, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (!w_instr_valid && !bus.halt && !bus.redirect && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue (DEPTH=16, RESET_PC=0x100).
// A behavioural memory with selectable latency answers requests; expected
// request addresses are queued by the stimulus and checked by a monitor,
// a consume table checks the decode side, and hand-written sequences cover
// redirect, drop, full, simultaneous write/consume and statistics.
module tb_prefetch_queue;
  localparam int          DEPTH = 16;
  localparam logic [31:0] RPC   = 32'h100;
`ifdef PREFETCH_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- memory model ----------------
  int          mode = 0;   // 0: word = address, 1: each byte = low byte of its address
  int          lat  = 1;   // response latency in cycles (1..15)
  logic        m_busy;
  logic [3:0]  m_cnt;
  logic [31:0] m_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mode == 0) return a;
    return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction

  // Expected 5-byte window at pc, derived from the memory contents.
  function automatic logic [39:0] win(input logic [31:0] pc);
    logic [39:0] r;
    logic [31:0] a;
    logic [31:0] w;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      a = pc + 32'(i);
      w = mem_word({a[31:2], 2'b00});
      r[8*i +: 8] = w[int'(a[1:0])*8 +: 8];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy         <= 1'b0;
      m_cnt          <= 4'd0;
      m_addr         <= 32'd0;
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= 32'd0;
    end else begin
      bus.mem_rvalid <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 4'd1) begin
          bus.mem_rvalid <= 1'b1;
          bus.mem_rdata  <= mem_word(m_addr);
          m_busy         <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 4'd1;
        end
      end
      if (bus.mem_req) begin
        if (lat == 1) begin
          bus.mem_rvalid <= 1'b1;
          bus.mem_rdata  <= mem_word(bus.mem_addr);
        end else begin
          m_busy <= 1'b1;
          m_cnt  <= 4'(lat - 1);
          m_addr <= bus.mem_addr;
        end
      end
    end
  end

  // ---------------- request scoreboard ----------------
  logic [31:0] exp_q [$];

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mem_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got request to 0x%0h, want no request", bus.mem_addr);
      end else begin
        chk("mem_addr", bus.mem_addr, exp_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      step();
      if (int'(bus.byte_count) == target) break;
    end
    chk(name, bus.byte_count, 64'(target));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"},   bus.mem_req,      0);
    chk({tag, "_mem_addr"},  bus.mem_addr,     64'(RPC));
    chk({tag, "_instr_pc"},  bus.instr_pc,     64'(RPC));
    chk({tag, "_count"},     bus.byte_count,   0);
    chk({tag, "_valid"},     bus.instr_valid,  0);
    chk({tag, "_stall"},     bus.stall_cycles, 0);
  endtask

  typedef struct {
    logic [2:0]  len;
    logic [31:0] pc;
    logic [4:0]  cnt;
    logic        valid;
  } vec_t;

  vec_t vt [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // consume table, applied from pc 0x203 with 13 bytes buffered, halted
    vt[0] = '{3'd1, 32'h204, 5'd12, 1'b1};
    vt[1] = '{3'd5, 32'h209, 5'd7,  1'b1};
    vt[2] = '{3'd2, 32'h20B, 5'd5,  1'b1};
    vt[3] = '{3'd5, 32'h210, 5'd0,  1'b0};
    vt[4] = '{3'd3, 32'h210, 5'd0,  1'b0};  // no instr_valid: ignored

    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.halt        = 1'b0;
    bus.consume     = 1'b0;
    bus.consume_len = 3'd0;

    // ---- reset state, then fill to full with 1-cycle memory ----
    repeat (3) step();
    chk_reset("R");
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    rst = 1'b1;
    wait_count(8, 20, "A_count8");
    chk("A_instr", bus.instr, 40'h04_0000_0100);
    chk("A_pc",    bus.instr_pc, 32'h100);
    chk("A_valid", bus.instr_valid, 1);
    wait_count(16, 20, "A_full");
    repeat (6) step();
    chk("A_full_count", bus.byte_count, 16);
    chk("A_full_req",   bus.mem_req, 0);
    chk("A_req_done",   exp_q.size(), 0);
    bus.consume = 1'b1; bus.consume_len = 3'd3;
    step();
    bus.consume = 1'b0;
    chk("A_c3_count", bus.byte_count, 13);
    chk("A_c3_req",   bus.mem_req, 0);
    chk("A_c3_pc",    bus.instr_pc, 32'h103);
    exp_q.push_back(32'h110);
    bus.consume = 1'b1; bus.consume_len = 3'd2;
    step();
    bus.consume = 1'b0;
    chk("A_c2_pc",    bus.instr_pc, 32'h105);
    chk("A_c2_count", bus.byte_count, 11);
    wait_count(15, 10, "A_refill");
    chk("A_instr2", bus.instr, win(32'h105));
    chk("A_q_empty", exp_q.size(), 0);

    // ---- unaligned redirect to 0x203, byte pattern memory ----
    mode = 1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    exp_q.push_back(32'h20C);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
    step();
    bus.redirect = 1'b0;
    chk("B_count0", bus.byte_count, 0);
    chk("B_pc",     bus.instr_pc, 32'h203);
    chk("B_valid0", bus.instr_valid, 0);
    wait_count(1, 10, "B_count1");
    chk("B_byte0", bus.instr[7:0], 8'h03);
    wait_count(5, 10, "B_count5");
    chk("B_instr", bus.instr, 40'h07_0605_0403);
    chk("B_valid", bus.instr_valid, 1);
    wait_count(13, 20, "B_count13");
    chk("B_q_empty", exp_q.size(), 0);
    bus.halt = 1'b1;

    // ---- consume table (halted, no fetch) ----
    for (int i = 0; i < 5; i++) begin
      bus.consume = 1'b1; bus.consume_len = vt[i].len;
      step();
      bus.consume = 1'b0;
      chk($sformatf("T%0d_pc", i),    bus.instr_pc,    vt[i].pc);
      chk($sformatf("T%0d_count", i), bus.byte_count,  vt[i].cnt);
      chk($sformatf("T%0d_valid", i), bus.instr_valid, vt[i].valid);
      if (vt[i].valid) chk($sformatf("T%0d_instr", i), bus.instr, win(vt[i].pc));
    end

    // ---- consume of 2 in the same cycle as a 4-byte write at count 6 ----
    exp_q.push_back(32'h210);
    exp_q.push_back(32'h214);
    bus.halt = 1'b0;
    wait_count(8, 20, "C_count8");
    bus.halt = 1'b1;
    chk("C_instr", bus.instr, win(32'h210));
    bus.consume = 1'b1; bus.consume_len = 3'd2;
    step();
    bus.consume = 1'b0;
    chk("C_count6", bus.byte_count, 6);
    exp_q.push_back(32'h218);
    bus.halt = 1'b0;
    step();
    bus.consume = 1'b1; bus.consume_len = 3'd2; bus.halt = 1'b1;
    step();
    bus.consume = 1'b0;
    chk("C_count8_after", bus.byte_count, 8);
    chk("C_pc",           bus.instr_pc, 32'h214);
    chk("C_instr2",       bus.instr, win(32'h214));
    chk("C_q_empty",      exp_q.size(), 0);

    // ---- redirect while WAIT with 3-cycle memory: stale data dropped ----
    lat = 3;
    exp_q.push_back(32'h21C);
    bus.halt = 1'b0;
    step();
    exp_q.push_back(32'h300);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    step();
    bus.redirect = 1'b0;
    chk("D_count_redir", bus.byte_count, 0);
    chk("D_pc",          bus.instr_pc, 32'h300);
    step();
    chk("D_count_drop1", bus.byte_count, 0);
    step();
    chk("D_count_drop2", bus.byte_count, 0);
    chk("D_valid_drop",  bus.instr_valid, 0);
    step();
    bus.halt = 1'b1;
    chk("D_q_empty", exp_q.size(), 0);
    chk("D_count_issue", bus.byte_count, 0);
    wait_count(4, 10, "D_refill");
    chk("D_word", bus.instr[31:0], 32'h0302_0100);
    chk("D_pc2",  bus.instr_pc, 32'h300);

    // ---- reset mid-operation, then starvation counter ----
    mode = 0;
    lat  = 15;
    rst  = 1'b0;
    repeat (2) step();
    chk_reset("E");
    rst = 1'b1;
    repeat (3) step();
    chk("E_stall_halt0", bus.stall_cycles, 0);
    exp_q.push_back(32'h100);
    bus.halt = 1'b0;
    repeat (10) step();
    bus.halt = 1'b1;
    chk("E_stall10",    bus.stall_cycles, EXP_STALL);
    chk("E_count_pend", bus.byte_count, 0);
    repeat (3) step();
    chk("E_stall_frozen", bus.stall_cycles, EXP_STALL);
    wait_count(4, 20, "E_resp_halted");
    chk("E_stall_final", bus.stall_cycles, EXP_STALL);
    chk("E_pc",          bus.instr_pc, 32'h100);
    chk("E_q_empty",     exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
